// File: rtl/normalizer_fxdiv.sv
// Unsigned fixed-point restoring divider: out = floor((in1 << FRAC) / in2), one quotient bit per cycle.
// Latency is fixed at WIDTH+FRAC cycles regardless of operands so paired lanes finish together.
module normalizer_fxdiv #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             rdy,
  output logic             busy,
  output logic             div_zero,
  output logic             ovf
);
  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;

  logic [N-1:0]     d, q, q_nx;
  logic [WIDTH-1:0] v;
  logic [WIDTH:0]   r, t, r_nx;
  logic [CW-1:0]    cnt;
  logic             ge, last;

  // T < 2V always holds, so a WIDTH+1 compare is enough for each quotient bit
  always_comb begin
    t    = {r[WIDTH-1:0], d[N-1]};
    ge   = (t >= {1'b0, v});
    r_nx = ge ? (t - {1'b0, v}) : t;
    q_nx = {q[N-2:0], ge};
    last = (cnt == '0);
  end

  always_comb begin
    state_nx = state;
    if (start)                    state_nx = RUN;
    else if (state == RUN && last) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d <= '0; v <= '0; r <= '0; q <= '0; cnt <= '0;
      out <= '0; rdy <= 1'b0; busy <= 1'b0; div_zero <= 1'b0; ovf <= 1'b0;
    end else if (start) begin
      // a start in RUN aborts and restarts; out holds the last result
      d    <= {in1, {FRAC{1'b0}}};
      v    <= in2;
      r    <= '0;
      q    <= '0;
      cnt  <= CW'(N-1);
      rdy  <= 1'b0;
      busy <= 1'b1;
    end else if (state == RUN) begin
      d   <= {d[N-2:0], 1'b0};
      r   <= r_nx;
      q   <= q_nx;
      cnt <= cnt - CW'(1);
      if (last) begin
        rdy  <= 1'b1;
        busy <= 1'b0;
        if (v == '0) begin
          out <= '1; div_zero <= 1'b1; ovf <= 1'b0;
        end else if (q_nx[N-1:WIDTH] != '0) begin
          out <= '1; div_zero <= 1'b0; ovf <= 1'b1;
        end else begin
          out <= q_nx[WIDTH-1:0]; div_zero <= 1'b0; ovf <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_normalizer_fxdiv.sv
// Scoreboard bench for normalizer_fxdiv: two lanes share start; expectations come from a reference divide.
module tb_normalizer_fxdiv;
  typedef struct packed {
    logic [31:0] o;
    logic        dz;
    logic        ov;
  } res_t;

  logic        clk = 1'b0, rst, start;
  logic [31:0] a0, b0, a1, b1;
  logic [31:0] out0, out1;
  logic        rdy0, rdy1, busy0, busy1, dz0, dz1, ov0, ov1;
  int          checks = 0, failures = 0;
  res_t        sb0[$], sb1[$];

  always #5 clk = ~clk;

  normalizer_fxdiv #(.WIDTH(32), .FRAC(16)) u0 (
    .clk(clk), .rst(rst), .in1(a0), .in2(b0), .start(start),
    .out(out0), .rdy(rdy0), .busy(busy0), .div_zero(dz0), .ovf(ov0));
  normalizer_fxdiv #(.WIDTH(32), .FRAC(16)) u1 (
    .clk(clk), .rst(rst), .in1(a1), .in2(b1), .start(start),
    .out(out1), .rdy(rdy1), .busy(busy1), .div_zero(dz1), .ovf(ov1));

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] num, qq;
    res_t r;
    num = {a, 16'h0};
    r.o = 32'hFFFF_FFFF; r.dz = 1'b0; r.ov = 1'b0;
    if (b == 32'd0) r.dz = 1'b1;
    else begin
      qq = num / {16'h0, b};
      if (qq[47:32] != 16'h0) r.ov = 1'b1;
      else r.o = qq[31:0];
    end
    return r;
  endfunction

  // Drive at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [31:0] x0, y0, x1, y1);
    a0 = x0; b0 = y0; a1 = x1; b1 = y1; start = 1'b1;
    sb0.push_back(model(x0, y0));
    sb1.push_back(model(x1, y1));
    @(negedge clk);
    start = 1'b0;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    checks++;
    if (rdy0 !== 1'b0 || rdy1 !== 1'b0 || busy0 !== 1'b1) begin
      failures++;
      $display("FAIL start_accept: rdy0=%b rdy1=%b busy0=%b required rdy=0 busy=1", rdy0, rdy1, busy0);
    end
  endtask

  task automatic wait_done(input int exp_lat, input string name);
    int k;
    res_t e0, e1;
    k = 0;
    while (!rdy0 && k < 200) begin @(negedge clk); k++; end
    checks++;
    if (k !== exp_lat) begin
      failures++;
      $display("FAIL %s_latency: got %0d cycles required %0d", name, k, exp_lat);
    end
    checks++;
    if (rdy1 !== rdy0) begin
      failures++;
      $display("FAIL %s_lane_align: rdy0=%b rdy1=%b required equal", name, rdy0, rdy1);
    end
    if (sb0.size() == 0 || sb1.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s_scoreboard: empty queue required entry", name);
    end else begin
      e0 = sb0.pop_front(); e1 = sb1.pop_front();
      checks++;
      if ({out0, dz0, ov0} !== e0) begin
        failures++;
        $display("FAIL %s_lane0: out=%h dz=%b ovf=%b required out=%h dz=%b ovf=%b",
                 name, out0, dz0, ov0, e0.o, e0.dz, e0.ov);
      end
      checks++;
      if ({out1, dz1, ov1} !== e1) begin
        failures++;
        $display("FAIL %s_lane1: out=%h dz=%b ovf=%b required out=%h dz=%b ovf=%b",
                 name, out1, dz1, ov1, e1.o, e1.dz, e1.ov);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    @(negedge clk);
    checks++;
    if ({out0, rdy0, busy0, dz0, ov0} !== 36'h0) begin
      failures++;
      $display("FAIL reset_state: out=%h rdy=%b busy=%b dz=%b ovf=%b required all 0", out0, rdy0, busy0, dz0, ov0);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    start_op(32'h0003_0000, 32'h0004_0000, 32'h1234_0000, 32'h1234_0000);
    wait_done(48, "basic_a");
    start_op(32'h0000_0001, 32'h0000_0003, 32'h0000_0000, 32'h0010_0000);
    wait_done(48, "basic_b");
    start_op(32'hDEAD_BEEF, 32'h0123_4567, 32'h0000_FFFF, 32'hFFFF_FFFF);
    wait_done(48, "basic_c");
  endtask

  task automatic test_flags();
    start_op(32'h0005_0000, 32'h0000_0000, 32'h0001_0000, 32'h0000_0001);
    wait_done(48, "flags_a");
    start_op(32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(48, "flags_b");
  endtask

  task automatic test_abort();
    start_op(32'h0003_0000, 32'h0004_0000, 32'h0005_0000, 32'h0000_0000);
    repeat (19) @(negedge clk);
    void'(sb0.pop_back()); void'(sb1.pop_back());
    start_op(32'h1234_0000, 32'h1234_0000, 32'h0000_0001, 32'h0000_0003);
    wait_done(48, "abort");
  endtask

  task automatic test_hold();
    logic [31:0] held;
    int bad;
    held = out0; bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (rdy0 !== 1'b1 || out0 !== held) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold: %0d unstable cycles required 0", bad);
    end
    start_op(32'h0000_0002, 32'h0000_0004, 32'h0000_0002, 32'h0000_0004);
    wait_done(48, "after_hold");
  endtask

  task automatic test_async_reset();
    int bad;
    start_op(32'h0003_0000, 32'h0004_0000, 32'h0003_0000, 32'h0004_0000);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out0, rdy0, busy0, dz0, ov0} !== 36'h0 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: out=%h rdy=%b busy=%b dz=%b ovf=%b required all 0", out0, rdy0, busy0, dz0, ov0);
    end
    void'(sb0.pop_back()); void'(sb1.pop_back());
    @(negedge clk); @(negedge clk); rst = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (rdy0 !== 1'b0 || rdy1 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL post_reset_rdy: %0d cycles with rdy required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flags();
    test_abort();
    test_hold();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/normalizer_fxdiv.md
Name: normalizer_fxdiv

Overview:
- Fixed-point unsigned divider. It is the responder on the bX_in1/bX_in2/bX_start/bX_out/bX_rdy divider interface driven by the spectrum normalizer.
- Computes out = floor((in1 << FRAC) / in2) as an unsigned Q(WIDTH-FRAC).FRAC quotient, one quotient bit per cycle, using restoring division.
- Two instances sit beside the normalizer, one per spectrum lane. Both must have identical, data-independent latency so that the normalizer can sample both outputs on one rdy.

Parameters:
- WIDTH, 32, operand and quotient width in bits.
- FRAC, 16, fractional bits appended to the dividend. N = WIDTH+FRAC is the iteration count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in1  in  WIDTH  dividend, unsigned, sampled on start.
- in2  in  WIDTH  divisor, unsigned, sampled on start.
- start  in  1  single-cycle request pulse.
- out  out  WIDTH  quotient, registered, held until the next start.
- rdy  out  1  result valid, registered level.
- busy  out  1  iteration in progress.
- div_zero  out  1  last operation had in2 == 0.
- ovf  out  1  last quotient saturated.

Behaviour:
- Reset: the design reaches reset state immediately on rst high, independent of clk, and stays there while rst is high.
  - State = IDLE; out = 0; rdy, busy, div_zero and ovf = 0.
  - Internal quotient, remainder, dividend shift register and counter = 0.
- States are IDLE, RUN.
- IDLE, start = 1, on the edge:
  - Latch dividend D = {in1, FRAC'b0} (N bits) and divisor V = in2.
  - Remainder R = 0 (WIDTH+1 bits), quotient Q = 0 (N bits), counter = N-1.
  - rdy <= 0, busy <= 1, go to RUN.
  - out keeps its old value until completion.
- RUN, each edge:
  - T = {R[WIDTH-1:0], D[N-1]}; D <<= 1.
  - If T >= V: R = T - V and shift 1 into Q. Otherwise R = T and shift 0 into Q.
  - Counter decrements.
- RUN, edge with counter == 0 (the N-th RUN edge):
  - The final bit is included.
  - If V == 0: out <= all ones, div_zero <= 1, ovf <= 0.
  - Else if Q[N-1:WIDTH] != 0: out <= all ones, ovf <= 1, div_zero <= 0.
  - Else: out <= Q[WIDTH-1:0], both flags <= 0.
  - rdy <= 1, busy <= 0, go to IDLE.
- Latency:
  - start is sampled at edge E0 and rdy is high after edge E(N); 48 cycles for the defaults.
  - Latency is constant and independent of operand values, including zero operands and division by zero.
- rdy is a level. It stays high with out stable until the next accepted start, and drops on the edge that accepts start. It is therefore never high in the cycle after start.
- start while in RUN: abort the current operation and restart with the new operands. The counter reloads to N-1, rdy stays 0, and no result is produced for the aborted operation.
- start is ignored only while rst is high.
- in1 and in2 may change freely after the start edge; only latched values are used.
- Zero dividend gives out = 0 with normal latency, unless the divisor is zero.
- Async reset mid-RUN clears everything. No rdy pulse appears afterwards.
- The quotient bit always fits in a WIDTH+1 remainder compare: T < 2V ≤ 2^(WIDTH+1).

Test Plan:
- in1=0x0003_0000, in2=0x0004_0000, start pulse -> rdy rises exactly 48 cycles later; out=0x0000_C000; flags 0.
- in1=in2=0x1234_0000 -> out=0x0001_0000.
- in1=0x0000_0001, in2=0x0000_0003 -> out=0x0000_5555.
- in1=0, in2=0x0010_0000 -> out=0 after 48 cycles.
- in1=0x0005_0000, in2=0 -> out=0xFFFF_FFFF, div_zero=1 after 48 cycles.
- in1=0x0001_0000, in2=1 (quotient 2^32) -> out=0xFFFF_FFFF, ovf=1.
- Two instances, same start, different operands -> rdy asserted on the same cycle.
- Abort and reset:
  - start at cycle 0 (3/4 operands), then a second start at cycle 20 with in1=in2=0x1234_0000 -> no rdy at cycle 48; rdy at cycle 68 with out=0x0001_0000.
  - Assert rst asynchronously mid-RUN at cycle 10 -> all outputs 0 immediately; rdy stays 0 thereafter with no start.
- rdy held and out stable for 100 idle cycles after completion; the next start drops rdy on its accepting edge.
